// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types: hold encoding, controller FSM states, bus widths.
package pipe_ctrl_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int REG_ADDR_W  = 5;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [REG_ADDR_W-1:0]  reg_addr_t;

  localparam inst_addr_t INST_ADDR_ZERO = '0;
  localparam reg_addr_t  REG_ADDR_ZERO  = '0;

  // A stage keeps its contents on WAIT and loads its default (bubble) on FLUSH.
  typedef enum logic [1:0] {
    HOLD_NONE  = 2'd0,
    HOLD_WAIT  = 2'd1,
    HOLD_FLUSH = 2'd2
  } holdpip_t;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard inputs from the pipeline and per-stage hold / redirect outputs of the controller.
interface pipe_ctrl_if #(
  parameter int CNT_W = 32
);
  import pipe_ctrl_pkg::*;

  logic       mem_busy_i;
  logic       muldiv_busy_i;
  logic       jump_en_i;
  inst_addr_t jump_addr_i;
  logic       ex_is_load_i;
  reg_addr_t  ex_w_reg_addr_i;
  reg_addr_t  id_r_reg_addr_1_i;
  reg_addr_t  id_r_reg_addr_2_i;
  logic       id_use_1_i;
  logic       id_use_2_i;

  holdpip_t   hold_pc_o;
  holdpip_t   hold_if_id_o;
  holdpip_t   hold_id_ex_o;
  holdpip_t   hold_ex_mem_o;
  logic       jump_en_o;
  inst_addr_t jump_addr_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport master (
    output mem_busy_i, muldiv_busy_i, jump_en_i, jump_addr_i,
           ex_is_load_i, ex_w_reg_addr_i,
           id_r_reg_addr_1_i, id_r_reg_addr_2_i, id_use_1_i, id_use_2_i,
    input  hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o,
           jump_en_o, jump_addr_o, stall_cnt_o
  );

  modport slave (
    input  mem_busy_i, muldiv_busy_i, jump_en_i, jump_addr_i,
           ex_is_load_i, ex_w_reg_addr_i,
           id_r_reg_addr_1_i, id_r_reg_addr_2_i, id_use_1_i, id_use_2_i,
    output hold_pc_o, hold_if_id_o, hold_id_ex_o, hold_ex_mem_o,
           jump_en_o, jump_addr_o, stall_cnt_o
  );

endinterface

// File: rtl/pipe_ctrl_hazard_det.sv
// Load-use detector: EX load destination matched against used ID sources.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the result only feeds the controller's priority logic.
module hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic      ex_is_load,
  input  reg_addr_t ex_w_reg_addr,
  input  reg_addr_t id_r_reg_addr_1,
  input  reg_addr_t id_r_reg_addr_2,
  input  logic      id_use_1,
  input  logic      id_use_2,
  output logic      load_use
);

  logic match_1;
  logic match_2;

  // x0 is never a real dependency, so a load into it cannot cause a stall.
  assign match_1  = id_use_1 && (id_r_reg_addr_1 == ex_w_reg_addr);
  assign match_2  = id_use_2 && (id_r_reg_addr_2 == ex_w_reg_addr);
  assign load_use = ex_is_load && (ex_w_reg_addr != REG_ADDR_ZERO) && (match_1 || match_2);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-stage hold flags, PC redirect, deferred jumps across memory stalls.
// Latency: hold/jump outputs are combinational (0 cycles); pending jump issues the cycle the bus frees.
// Backpressure: mem_busy_i freezes every stage and defers redirects until the bus is ready.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  ctl
);

  ctrl_state_t      state;
  ctrl_state_t      state_nxt;
  logic             pend_v;
  inst_addr_t       pend_addr;
  logic [CNT_W-1:0] stall_cnt;
  logic             load_use;

  hazard_det u_hazard_det (
    .ex_is_load      (ctl.ex_is_load_i),
    .ex_w_reg_addr   (ctl.ex_w_reg_addr_i),
    .id_r_reg_addr_1 (ctl.id_r_reg_addr_1_i),
    .id_r_reg_addr_2 (ctl.id_r_reg_addr_2_i),
    .id_use_1        (ctl.id_use_1_i),
    .id_use_2        (ctl.id_use_2_i),
    .load_use        (load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      pend_v    <= 1'b0;
      pend_addr <= INST_ADDR_ZERO;
      stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      // A redirect seen during a memory stall is kept; the newest one wins.
      if (ctl.mem_busy_i && ctl.jump_en_i) begin
        pend_v    <= 1'b1;
        pend_addr <= ctl.jump_addr_i;
      end else if (!ctl.mem_busy_i && pend_v) begin
        pend_v <= 1'b0;
      end
      if (ctl.hold_pc_o == HOLD_WAIT) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:      if (ctl.mem_busy_i)  state_nxt = ST_MEM_WAIT;
      ST_MEM_WAIT: if (!ctl.mem_busy_i) state_nxt = ST_RUN;
      default:     state_nxt = ST_RUN;
    endcase
  end

  // Priority: reset > mem stall > pending jump > new jump > muldiv > load-use.
  always_comb begin
    ctl.hold_pc_o     = HOLD_NONE;
    ctl.hold_if_id_o  = HOLD_NONE;
    ctl.hold_id_ex_o  = HOLD_NONE;
    ctl.hold_ex_mem_o = HOLD_NONE;
    ctl.jump_en_o     = 1'b0;
    ctl.jump_addr_o   = INST_ADDR_ZERO;
    if (rst) begin
      ctl.hold_pc_o     = HOLD_FLUSH;
      ctl.hold_if_id_o  = HOLD_FLUSH;
      ctl.hold_id_ex_o  = HOLD_FLUSH;
      ctl.hold_ex_mem_o = HOLD_FLUSH;
    end else if (ctl.mem_busy_i) begin
      ctl.hold_pc_o     = HOLD_WAIT;
      ctl.hold_if_id_o  = HOLD_WAIT;
      ctl.hold_id_ex_o  = HOLD_WAIT;
      ctl.hold_ex_mem_o = HOLD_WAIT;
    end else if (pend_v) begin
      ctl.jump_en_o    = 1'b1;
      ctl.jump_addr_o  = pend_addr;
      ctl.hold_if_id_o = HOLD_FLUSH;
      ctl.hold_id_ex_o = HOLD_FLUSH;
    end else if (ctl.jump_en_i) begin
      // The flushed ID instruction makes any coincident load-use moot.
      ctl.jump_en_o    = 1'b1;
      ctl.jump_addr_o  = ctl.jump_addr_i;
      ctl.hold_if_id_o = HOLD_FLUSH;
      ctl.hold_id_ex_o = HOLD_FLUSH;
    end else if (ctl.muldiv_busy_i) begin
      ctl.hold_pc_o     = HOLD_WAIT;
      ctl.hold_if_id_o  = HOLD_WAIT;
      ctl.hold_id_ex_o  = HOLD_WAIT;
      ctl.hold_ex_mem_o = HOLD_FLUSH;
    end else if (load_use) begin
      ctl.hold_pc_o    = HOLD_WAIT;
      ctl.hold_if_id_o = HOLD_WAIT;
      ctl.hold_id_ex_o = HOLD_FLUSH;
    end
  end

  assign ctl.stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hand-computed hold/jump/counter values per step.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipe_ctrl_if #(.CNT_W(32)) bus ();

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input holdpip_t pc, input holdpip_t if_id,
                           input holdpip_t id_ex, input holdpip_t ex_mem,
                           input logic jen, input logic [31:0] jaddr);
    check({tag, ".pc"},     32'(bus.hold_pc_o),     32'(pc));
    check({tag, ".if_id"},  32'(bus.hold_if_id_o),  32'(if_id));
    check({tag, ".id_ex"},  32'(bus.hold_id_ex_o),  32'(id_ex));
    check({tag, ".ex_mem"}, 32'(bus.hold_ex_mem_o), 32'(ex_mem));
    check({tag, ".jen"},    32'(bus.jump_en_o),     32'(jen));
    check({tag, ".jaddr"},  bus.jump_addr_o,        jaddr);
  endtask

  task automatic idle();
    bus.mem_busy_i        = 1'b0;
    bus.muldiv_busy_i     = 1'b0;
    bus.jump_en_i         = 1'b0;
    bus.jump_addr_i       = '0;
    bus.ex_is_load_i      = 1'b0;
    bus.ex_w_reg_addr_i   = '0;
    bus.id_r_reg_addr_1_i = '0;
    bus.id_r_reg_addr_2_i = '0;
    bus.id_use_1_i        = 1'b0;
    bus.id_use_2_i        = 1'b0;
  endtask

  task automatic load_use_match();
    bus.ex_is_load_i      = 1'b1;
    bus.ex_w_reg_addr_i   = 5'd5;
    bus.id_r_reg_addr_1_i = 5'd5;
    bus.id_use_1_i        = 1'b1;
  endtask

  // Advance one edge, then settle inputs away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle();
    #1;
    check_out("rst_comb", HOLD_FLUSH, HOLD_FLUSH, HOLD_FLUSH, HOLD_FLUSH, 1'b0, 32'h0);
    tick();
    tick();
    check("rst_cnt", bus.stall_cnt_o, 32'd0);

    rst = 1'b0;
    #1;
    check_out("idle", HOLD_NONE, HOLD_NONE, HOLD_NONE, HOLD_NONE, 1'b0, 32'h0);

    // Load-use bubble for one cycle.
    load_use_match();
    #1;
    check_out("lu", HOLD_WAIT, HOLD_WAIT, HOLD_FLUSH, HOLD_NONE, 1'b0, 32'h0);
    tick();
    idle();
    #1;
    check("lu_cnt", bus.stall_cnt_o, 32'd1);
    check_out("lu_after", HOLD_NONE, HOLD_NONE, HOLD_NONE, HOLD_NONE, 1'b0, 32'h0);

    // Load into x0 is not a hazard.
    load_use_match();
    bus.ex_w_reg_addr_i = 5'd0;
    bus.id_r_reg_addr_1_i = 5'd0;
    #1;
    check_out("lu_x0", HOLD_NONE, HOLD_NONE, HOLD_NONE, HOLD_NONE, 1'b0, 32'h0);

    // Match on the second source only, but its use flag clear.
    idle();
    bus.ex_is_load_i = 1'b1;
    bus.ex_w_reg_addr_i = 5'd7;
    bus.id_r_reg_addr_2_i = 5'd7;
    #1;
    check("lu_nouse", 32'(bus.hold_pc_o), 32'(HOLD_NONE));
    bus.id_use_2_i = 1'b1;
    #1;
    check_out("lu_rs2", HOLD_WAIT, HOLD_WAIT, HOLD_FLUSH, HOLD_NONE, 1'b0, 32'h0);
    tick();
    idle();
    #1;
    check("lu_rs2_cnt", bus.stall_cnt_o, 32'd2);

    // Multi-cycle unit busy for four cycles.
    for (int i = 0; i < 4; i++) begin
      bus.muldiv_busy_i = 1'b1;
      #1;
      check_out($sformatf("md%0d", i), HOLD_WAIT, HOLD_WAIT, HOLD_WAIT, HOLD_FLUSH, 1'b0, 32'h0);
      tick();
    end
    idle();
    #1;
    check("md_cnt", bus.stall_cnt_o, 32'd6);

    // Memory stall for three cycles with a jump arriving in the second.
    for (int i = 0; i < 3; i++) begin
      bus.mem_busy_i  = 1'b1;
      bus.jump_en_i   = (i == 1);
      bus.jump_addr_i = (i == 1) ? 32'h100 : 32'h0;
      #1;
      check_out($sformatf("mem%0d", i), HOLD_WAIT, HOLD_WAIT, HOLD_WAIT, HOLD_WAIT, 1'b0, 32'h0);
      tick();
    end
    idle();
    #1;
    check_out("mem_rel", HOLD_NONE, HOLD_FLUSH, HOLD_FLUSH, HOLD_NONE, 1'b1, 32'h100);
    check("mem_cnt", bus.stall_cnt_o, 32'd9);
    tick();
    check_out("mem_post", HOLD_NONE, HOLD_NONE, HOLD_NONE, HOLD_NONE, 1'b0, 32'h0);

    // A later jump during the stall overwrites the pending one.
    bus.mem_busy_i = 1'b1;
    bus.jump_en_i = 1'b1;
    bus.jump_addr_i = 32'h40;
    tick();
    bus.jump_addr_i = 32'h44;
    tick();
    idle();
    #1;
    check_out("ovw_rel", HOLD_NONE, HOLD_FLUSH, HOLD_FLUSH, HOLD_NONE, 1'b1, 32'h44);
    check("ovw_cnt", bus.stall_cnt_o, 32'd11);
    tick();

    // Jump wins over a coincident load-use.
    load_use_match();
    bus.jump_en_i = 1'b1;
    bus.jump_addr_i = 32'h80;
    #1;
    check_out("jmp_lu", HOLD_NONE, HOLD_FLUSH, HOLD_FLUSH, HOLD_NONE, 1'b1, 32'h80);
    tick();
    check("jmp_lu_cnt", bus.stall_cnt_o, 32'd11);

    // Muldiv wins over load-use; mem stall wins over muldiv and jump.
    bus.jump_en_i = 1'b0;
    bus.muldiv_busy_i = 1'b1;
    #1;
    check_out("md_lu", HOLD_WAIT, HOLD_WAIT, HOLD_WAIT, HOLD_FLUSH, 1'b0, 32'h0);
    tick();
    bus.mem_busy_i = 1'b1;
    #1;
    check_out("mem_md", HOLD_WAIT, HOLD_WAIT, HOLD_WAIT, HOLD_WAIT, 1'b0, 32'h0);
    tick();
    idle();
    #1;
    check("prio_cnt", bus.stall_cnt_o, 32'd13);

    // Reset during a memory stall drops the pending jump.
    bus.mem_busy_i = 1'b1;
    bus.jump_en_i = 1'b1;
    bus.jump_addr_i = 32'h200;
    #1;
    check("rst_mw_pre", 32'(bus.hold_pc_o), 32'(HOLD_WAIT));
    tick();
    rst = 1'b1;
    bus.jump_en_i = 1'b0;
    #1;
    check_out("rst_mw", HOLD_FLUSH, HOLD_FLUSH, HOLD_FLUSH, HOLD_FLUSH, 1'b0, 32'h0);
    tick();
    rst = 1'b0;
    idle();
    #1;
    check_out("rst_rel", HOLD_NONE, HOLD_NONE, HOLD_NONE, HOLD_NONE, 1'b0, 32'h0);
    check("rst_rel_cnt", bus.stall_cnt_o, 32'd0);
    tick();
    check("rst_rel_jen2", 32'(bus.jump_en_o), 32'd0);
    check("rst_rel_cnt2", bus.stall_cnt_o, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
